// File: rtl/apb_regfile_slave.sv
// APB slave with a 16-word register file (ID, 14 general R/W words, WAIT) and programmable wait states.
// Optional PSLVERR reporting is enabled with `define APB_REGFILE_SLVERR_EN.
`timescale 1ns/1ps
module apb_regfile_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0300
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              wait_q;
  logic [3:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   gp_q [1:14];
  logic [3:0]              idx;
  logic                    err;
  logic                    setup;
  logic                    access_ok;
  logic                    ready_set;
  logic                    complete;
  logic                    do_write;
  logic [DATA_WIDTH-1:0]   rd_val;

  assign idx       = PADDR[5:2];
  assign setup     = PSEL & ~PENABLE;
  assign access_ok = PSEL & PENABLE;
  assign err       = (PADDR[1:0] != 2'b00) || (PADDR[ADDR_WIDTH-1:6] != '0) ||
                     (PWRITE && idx == 4'd0);
  assign do_write  = complete && PWRITE && !err;

  always_comb begin
    rd_val = '0;
    if (idx == 4'd0)       rd_val = ID_VALUE;
    else if (idx == 4'd15) rd_val[3:0] = wait_q;
    else                   rd_val = gp_q[idx];
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ready_set = 1'b0;
    complete  = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          state_d   = ACCESS;
          ready_set = (wait_q == 4'd0);
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (PREADY) begin
            state_d  = IDLE;
            complete = 1'b1;
          end else begin
            // Ready is registered, so it is raised one cycle ahead of the final wait.
            ready_set = (cnt_q <= 4'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
      // NOTE: the register file is architecturally reset, so the array is cleared here too.
      for (int i = 1; i <= 14; i++) gp_q[i] <= '0;
    end else begin
      PREADY <= ready_set;
      PRDATA <= (ready_set && !PWRITE && !err) ? rd_val : '0;
      if (state_q == IDLE && setup)
        cnt_q <= wait_q;
      else if (state_q == ACCESS && access_ok && !PREADY && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      if (do_write) begin
        if (idx == 4'd15) wait_q    <= PWDATA[3:0];
        else              gp_q[idx] <= PWDATA;
      end
    end
  end

`ifdef APB_REGFILE_SLVERR_EN
  always_ff @(posedge PCLK) begin
    if (PRESET) PSLVERR <= 1'b0;
    else        PSLVERR <= ready_set && err;
  end
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed self-checking bench for apb_regfile_slave: ID read, wait states, errors, abort, reset, back-to-back.
`timescale 1ns/1ps
module tb_apb_regfile_slave;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int vectors = 0;
  int miscompares = 0;

`ifdef APB_REGFILE_SLVERR_EN
  localparam logic SLV_EN = 1'b1;
`else
  localparam logic SLV_EN = 1'b0;
`endif

  apb_regfile_slave dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transfer: setup, then access until PREADY; returns at the ready cycle with the bus still in access.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input int exp_wait,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int waits;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    check({tag, " setup_ready"}, {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    @(negedge PCLK);
    while (PREADY !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge PCLK);
    end
    check({tag, " waits"}, 32'(waits), 32'(exp_wait));
    check({tag, " prdata"}, PRDATA, exp_rdata);
    check({tag, " pslverr"}, {31'd0, PSLVERR}, {31'd0, exp_err & SLV_EN});
  endtask

  task automatic bus_idle(input string tag);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check({tag, " ready_drop"}, {31'd0, PREADY}, 32'd0);
  endtask

  initial begin
    int seen;

    // Reset
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst pready", {31'd0, PREADY}, 32'd0);
    check("rst prdata", PRDATA, 32'd0);
    check("rst pslverr", {31'd0, PSLVERR}, 32'd0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // ID read with zero wait states
    xfer("rd_id", 1'b0, 32'h00, 32'h0, 0, 32'hA9B0_0300, 1'b0);
    bus_idle("rd_id");

    // Program WAIT=3, then every later transfer sees three wait cycles
    xfer("wr_wait3", 1'b1, 32'h3C, 32'h3, 0, 32'h0, 1'b0);
    bus_idle("wr_wait3");
    xfer("wr_04", 1'b1, 32'h04, 32'hDEAD_BEEF, 3, 32'h0, 1'b0);
    bus_idle("wr_04");
    xfer("rd_04", 1'b0, 32'h04, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    bus_idle("rd_04");
    xfer("rd_3c", 1'b0, 32'h3C, 32'h0, 3, 32'h3, 1'b0);
    bus_idle("rd_3c");

    // Error responses
    xfer("wr_40", 1'b1, 32'h40, 32'h1, 3, 32'h0, 1'b1);
    bus_idle("wr_40");
    xfer("wr_06", 1'b1, 32'h06, 32'h1, 3, 32'h0, 1'b1);
    bus_idle("wr_06");
    xfer("wr_00", 1'b1, 32'h00, 32'h0, 3, 32'h0, 1'b1);
    bus_idle("wr_00");
    xfer("rd_41", 1'b0, 32'h41, 32'h0, 3, 32'h0, 1'b1);
    bus_idle("rd_41");
    xfer("rd_04_after_err", 1'b0, 32'h04, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    bus_idle("rd_04_after_err");
    xfer("rd_id_after_err", 1'b0, 32'h00, 32'h0, 3, 32'hA9B0_0300, 1'b0);
    bus_idle("rd_id_after_err");

    // Abort: WAIT=5, drop PSEL after two access cycles
    xfer("wr_wait5", 1'b1, 32'h3C, 32'h5, 3, 32'h0, 1'b0);
    bus_idle("wr_wait5");
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h1234_5678;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    seen = 0;
    repeat (2) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) seen++;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (8) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) seen++;
    end
    check("abort ready_seen", 32'(seen), 32'd0);
    xfer("rd_08_abort", 1'b0, 32'h08, 32'h0, 5, 32'h0, 1'b0);
    bus_idle("rd_08_abort");

    // PENABLE without a setup cycle is ignored
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'hFF;
    seen = 0;
    repeat (10) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) seen++;
    end
    check("no_setup ready_seen", 32'(seen), 32'd0);
    bus_idle("no_setup");
    xfer("rd_08_no_setup", 1'b0, 32'h08, 32'h0, 5, 32'h0, 1'b0);
    bus_idle("rd_08_no_setup");

    // Reset during the wait phase of a write to 0x0C
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C; PWDATA = 32'hAAAA_5555;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    check("rst_mid pready", {31'd0, PREADY}, 32'd0);
    check("rst_mid prdata", PRDATA, 32'd0);
    xfer("rd_0c_rst", 1'b0, 32'h0C, 32'h0, 0, 32'h0, 1'b0);
    bus_idle("rd_0c_rst");
    xfer("rd_3c_rst", 1'b0, 32'h3C, 32'h0, 0, 32'h0, 1'b0);
    bus_idle("rd_3c_rst");

    // Back-to-back transfers with WAIT=0
    xfer("b2b_wr_10", 1'b1, 32'h10, 32'h7, 0, 32'h0, 1'b0);
    xfer("b2b_rd_10", 1'b0, 32'h10, 32'h0, 0, 32'h7, 1'b0);
    bus_idle("b2b_rd_10");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
